// File: rtl/bitstream_separator.sv
`default_nettype none
// ============================================================================
// Module   : bitstream_separator
// Purpose  : Captures a WIDTH-bit word at the start of every frame and emits
//            it as N = WIDTH/DWIDTH consecutive DWIDTH-bit chunks, one per
//            clock, either most- or least-significant chunk first.
//            Frames run back-to-back with no handshake and no idle cycles.
// Options  : `define BITSTREAM_SEPARATOR_DONE_EN to add the registered
//            one-cycle 'done' last-chunk flag.
// Revision : 1.0 - initial release
// ============================================================================
module bitstream_separator #(
    parameter int WIDTH     = 32,
    parameter int DWIDTH    = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [WIDTH-1:0]  data_serial,
    output logic [DWIDTH-1:0] bitstream
`ifdef BITSTREAM_SEPARATOR_DONE_EN
    ,
    output logic              done
`endif
);

    // Chunks per frame and the counter width needed to index them.
    localparam int c_n     = WIDTH / DWIDTH;
    localparam int c_cnt_w = (c_n > 1) ? $clog2(c_n) : 1;

    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_n - 1);

    logic [WIDTH-1:0]   word_q, word_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [DWIDTH-1:0]  bitstream_q, bitstream_d;

    // Chunk view of the captured word, ordered in emission order.
    logic [DWIDTH-1:0]  w_word_chunk [c_n];
    // First chunk of the live input, used on the frame-start edge so the
    // output does not wait a cycle for the word register to load.
    logic [DWIDTH-1:0]  w_in_chunk0;
    logic               w_frame_start;

    generate
        for (genvar gi = 0; gi < c_n; gi++) begin : g_chunk
            if (MSB_FIRST != 0) begin : g_msb
                assign w_word_chunk[gi] = word_q[WIDTH-1-gi*DWIDTH -: DWIDTH];
            end else begin : g_lsb
                assign w_word_chunk[gi] = word_q[gi*DWIDTH +: DWIDTH];
            end
        end

        if (MSB_FIRST != 0) begin : g_in_msb
            assign w_in_chunk0 = data_serial[WIDTH-1 -: DWIDTH];
        end else begin : g_in_lsb
            assign w_in_chunk0 = data_serial[DWIDTH-1:0];
        end
    endgenerate

    assign w_frame_start = (cnt_q == '0);

    // Next-state: capture on frame start, otherwise hold the word and step
    // through its chunks, wrapping the counter after the last one.
    always_comb begin
        word_d      = word_q;
        cnt_d       = cnt_q;
        bitstream_d = bitstream_q;

        if (w_frame_start) begin
            word_d      = data_serial;
            bitstream_d = w_in_chunk0;
        end else begin
            bitstream_d = w_word_chunk[cnt_q];
        end

        if (cnt_q == c_cnt_last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + c_cnt_w'(1);
        end
    end

    // State registers, cleared asynchronously so reset is visible at once.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            word_q      <= '0;
            cnt_q       <= '0;
            bitstream_q <= '0;
        end else begin
            word_q      <= word_d;
            cnt_q       <= cnt_d;
            bitstream_q <= bitstream_d;
        end
    end

    assign bitstream = bitstream_q;

`ifdef BITSTREAM_SEPARATOR_DONE_EN
    logic done_q, done_d;

    // Flag goes high together with the last chunk of the frame.
    always_comb begin
        done_d = (cnt_q == c_cnt_last);
    end

    // Last-chunk flag register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign done = done_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bitstream_separator.sv
`default_nettype none
module tb_bitstream_separator;

    logic        clk  = 1'b0;
    logic        nrst = 1'b0;
    logic [31:0] data_serial = 32'hA5A5_A5A5;

    logic [7:0]  bs_a;   // MSB first, 8-bit chunks
    logic [7:0]  bs_b;   // LSB first, 8-bit chunks
    logic [3:0]  bs_c;   // MSB first, 4-bit chunks

    always #5 clk = ~clk;

`ifdef BITSTREAM_SEPARATOR_DONE_EN
    logic done_a, done_b, done_c;
`endif

    bitstream_separator #(.WIDTH(32), .DWIDTH(8), .MSB_FIRST(1)) u_a (
        .clk(clk), .nrst(nrst), .data_serial(data_serial), .bitstream(bs_a)
`ifdef BITSTREAM_SEPARATOR_DONE_EN
        , .done(done_a)
`endif
    );

    bitstream_separator #(.WIDTH(32), .DWIDTH(8), .MSB_FIRST(0)) u_b (
        .clk(clk), .nrst(nrst), .data_serial(data_serial), .bitstream(bs_b)
`ifdef BITSTREAM_SEPARATOR_DONE_EN
        , .done(done_b)
`endif
    );

    bitstream_separator #(.WIDTH(32), .DWIDTH(4), .MSB_FIRST(1)) u_c (
        .clk(clk), .nrst(nrst), .data_serial(data_serial), .bitstream(bs_c)
`ifdef BITSTREAM_SEPARATOR_DONE_EN
        , .done(done_c)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    logic [7:0] q_a [$];
    logic [7:0] q_b [$];
    logic [3:0] q_c [$];
    bit         qd_a [$];
    bit         qd_b [$];
    bit         qd_c [$];
    int         pos_a = 0;
    int         pos_b = 0;
    int         pos_c = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic exp_a(input logic [7:0] v);
        q_a.push_back(v);
        qd_a.push_back((pos_a % 4) == 3);
        pos_a++;
    endtask

    task automatic exp_b(input logic [7:0] v);
        q_b.push_back(v);
        qd_b.push_back((pos_b % 4) == 3);
        pos_b++;
    endtask

    task automatic exp_c(input logic [3:0] v);
        q_c.push_back(v);
        qd_c.push_back((pos_c % 8) == 7);
        pos_c++;
    endtask

    // Monitor: every enabled cycle each DUT must present the next queued chunk.
    always @(negedge clk) begin
        if (mon_en) begin
            if (q_a.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL bs_a: got 0x%0h expected nothing queued", bs_a);
            end else begin
                chk("bs_a", 32'(bs_a), 32'(q_a.pop_front()));
            end
            if (q_b.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL bs_b: got 0x%0h expected nothing queued", bs_b);
            end else begin
                chk("bs_b", 32'(bs_b), 32'(q_b.pop_front()));
            end
            if (q_c.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL bs_c: got 0x%0h expected nothing queued", bs_c);
            end else begin
                chk("bs_c", 32'(bs_c), 32'(q_c.pop_front()));
            end
`ifdef BITSTREAM_SEPARATOR_DONE_EN
            if (qd_a.size() != 0) chk("done_a", 32'(done_a), 32'(qd_a.pop_front()));
            if (qd_b.size() != 0) chk("done_b", 32'(done_b), 32'(qd_b.pop_front()));
            if (qd_c.size() != 0) chk("done_c", 32'(done_c), 32'(qd_c.pop_front()));
`endif
        end
    end

    initial begin
        logic [7:0] va [19];
        logic [7:0] vb [19];
        logic [3:0] vc [19];

        // Reset held with clock running and input present.
        repeat (3) @(posedge clk);
        #2;
        chk("reset_bs_a", 32'(bs_a), 32'h0);
        chk("reset_bs_b", 32'(bs_b), 32'h0);
        chk("reset_bs_c", 32'(bs_c), 32'h0);
`ifdef BITSTREAM_SEPARATOR_DONE_EN
        chk("reset_done_a", 32'(done_a), 32'h0);
        chk("reset_done_c", 32'(done_c), 32'h0);
`endif

        // Edges 1-5 see B4EADEFB, 6-13 see 12345678, 14-19 see B4EADEFB.
        va = '{8'hB4, 8'hEA, 8'hDE, 8'hFB, 8'hB4, 8'hEA, 8'hDE, 8'hFB,
               8'h12, 8'h34, 8'h56, 8'h78, 8'h12, 8'h34, 8'h56, 8'h78,
               8'hB4, 8'hEA, 8'hDE};
        vb = '{8'hFB, 8'hDE, 8'hEA, 8'hB4, 8'hFB, 8'hDE, 8'hEA, 8'hB4,
               8'h78, 8'h56, 8'h34, 8'h12, 8'h78, 8'h56, 8'h34, 8'h12,
               8'hFB, 8'hDE, 8'hEA};
        vc = '{4'hB, 4'h4, 4'hE, 4'hA, 4'hD, 4'hE, 4'hF, 4'hB,
               4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8,
               4'hB, 4'h4, 4'hE};
        for (int i = 0; i < 19; i++) begin
            exp_a(va[i]);
            exp_b(vb[i]);
            exp_c(vc[i]);
        end

        @(negedge clk);
        #1;
        data_serial = 32'hB4EA_DEFB;
        nrst   = 1'b1;
        mon_en = 1'b1;

        repeat (5) @(posedge clk);
        #1 data_serial = 32'h1234_5678;     // mid-frame change for A/B
        repeat (8) @(posedge clk);
        #1 data_serial = 32'hB4EA_DEFB;     // mid-frame change again
        repeat (6) @(posedge clk);          // edge 19: A shows 0xDE

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        nrst   = 1'b0;                      // asynchronous mid-frame reset
        #1;
        chk("async_reset_bs_a", 32'(bs_a), 32'h0);
        chk("async_reset_bs_b", 32'(bs_b), 32'h0);
        chk("async_reset_bs_c", 32'(bs_c), 32'h0);
`ifdef BITSTREAM_SEPARATOR_DONE_EN
        chk("async_reset_done_a", 32'(done_a), 32'h0);
`endif
        chk("drained_a", 32'(q_a.size()), 32'h0);
        chk("drained_b", 32'(q_b.size()), 32'h0);
        chk("drained_c", 32'(q_c.size()), 32'h0);

        // After release the first edge is a frame start on the live input.
        data_serial = 32'h1234_5678;
        pos_a = 0; pos_b = 0; pos_c = 0;
        qd_a.delete(); qd_b.delete(); qd_c.delete();
        for (int r = 0; r < 2; r++) begin
            exp_a(8'h12); exp_a(8'h34); exp_a(8'h56); exp_a(8'h78);
            exp_b(8'h78); exp_b(8'h56); exp_b(8'h34); exp_b(8'h12);
        end
        exp_c(4'h1); exp_c(4'h2); exp_c(4'h3); exp_c(4'h4);
        exp_c(4'h5); exp_c(4'h6); exp_c(4'h7); exp_c(4'h8);

        @(negedge clk);
        #1;
        nrst   = 1'b1;
        mon_en = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        chk("drained_a_end", 32'(q_a.size()), 32'h0);
        chk("drained_b_end", 32'(q_b.size()), 32'h0);
        chk("drained_c_end", 32'(q_c.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
